ring_nic: RTL

- Network interface between a processing element (PE) and the PE port of the bidirectional ring router.
- Provides a memory-mapped register window of 4 × 64-bit locations to the PE.
- Holds one output-channel packet for injection into the router (router pesi/peri/pedi) and one input-channel packet ejected by the router (router peso/pero/pedo).
- Injection is gated by router polarity so a packet only enters on its virtual-channel phase.

---
 rtl/ring_nic.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ring_nic.sv
// ring_nic: network interface between a processing element and the PE port
// of the bidirectional ring router.
//
// Holds one outbound packet (PE -> router) and one inbound packet
// (router -> PE) in single-entry buffers. The PE reaches them through
// a window of four 64-bit registers.
// Injection only happens when the router polarity matches the packet's
// virtual-channel bit.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   addr            PE register address (00 in-data, 01 in-status,
//                   10 out-data, 11 out-status)
//   d_in, d_out     PE write data, registered PE read data
//   nicEn, nicWrEn  PE access enable, 1 = write / 0 = read
//   net_polarity    router polarity (0 even cycle, 1 odd cycle)
//   net_so, net_ri  send to router PE input, router ready
//   net_do          outbound packet data
//   net_si, net_ro  router send on PE output, NIC ready
//   net_di          inbound packet data
//
// Optional build macro NIC_DROP_CNT_EN adds an 8-bit saturating counter of
// dropped out-data writes. The counter is reported in out-status bits [7:0].
module ring_nic #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned VC_BIT     = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_polarity,
  output logic                  net_so,
  input  logic                  net_ri,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_si,
  output logic                  net_ro,
  input  logic [DATA_WIDTH-1:0] net_di
);

  localparam logic [1:0] ADDR_IN_DATA    = 2'b00;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA   = 2'b10;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

  logic [DATA_WIDTH-1:0] in_buf_q,  in_buf_d;
  logic                  in_full_q, in_full_d;
  logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
  logic                  out_full_q, out_full_d;
  logic [DATA_WIDTH-1:0] d_out_q,   d_out_d;

  logic rd_c, wr_c, inject_c, eject_c;
  logic [DATA_WIDTH-1:0] in_status_c, out_status_c;

  // Access decode and router handshakes
  always_comb begin
    rd_c     = nicEn & ~nicWrEn;
    wr_c     = nicEn & nicWrEn;
    inject_c = out_full_q & net_ri & (net_polarity == out_buf_q[VC_BIT]);
    eject_c  = net_si & ~in_full_q;
  end

`ifdef NIC_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       drop_c;

  // A write to a full out-data register is lost; count it, saturating at 255
  always_comb begin
    drop_c     = wr_c & (addr == ADDR_OUT_DATA) & out_full_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  always_comb begin
    out_status_c             = '0;
    out_status_c[DATA_WIDTH-1] = out_full_q;
    out_status_c[7:0]        = drop_cnt_q;
  end
`else
  always_comb begin
    out_status_c             = '0;
    out_status_c[DATA_WIDTH-1] = out_full_q;
  end
`endif

  always_comb begin
    in_status_c             = '0;
    in_status_c[DATA_WIDTH-1] = in_full_q;
  end

  // Next state for buffers and read data
  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    d_out_d    = d_out_q;

    if (rd_c) begin
      unique case (addr)
        ADDR_IN_DATA:    d_out_d = in_buf_q;
        ADDR_IN_STATUS:  d_out_d = in_status_c;
        ADDR_OUT_DATA:   d_out_d = out_buf_q;
        ADDR_OUT_STATUS: d_out_d = out_status_c;
        default:         d_out_d = d_out_q;
      endcase
      if (addr == ADDR_IN_DATA) in_full_d = 1'b0;
    end

    // Ejection only possible while empty, so it never collides with a read clear
    if (eject_c) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end

    if (inject_c) out_full_d = 1'b0;

    // Acceptance judged on the sampled full flag; a write racing an injection is dropped
    if (wr_c && (addr == ADDR_OUT_DATA) && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      d_out_q    <= '0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      d_out_q    <= d_out_d;
    end
  end

  assign d_out  = d_out_q;
  assign net_do = out_buf_q;
  assign net_so = inject_c;
  assign net_ro = ~in_full_q;

endmodule
